// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register configuration bus arbiter:
// FSM state encoding, default geometry and bus direction codes.
package reg_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      GAP    = 2'd3
   } state_e;

   localparam int REG_W_WIDTH     = 8;
   localparam int REG_TIMEOUT_CYC = 16;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Register configuration bus as seen between the arbiter (master side)
// and the OR-ed per-register decoders (slave side).
interface reg_bus_arbiter_if
   import reg_bus_pkg::*;
#(
   parameter int W_WIDTH = REG_W_WIDTH
);
   logic               sel_en;
   logic               wr_rd_s;
   logic [W_WIDTH-1:0] addr;
   logic [W_WIDTH-1:0] wr_data;
   logic               ack;
   logic [W_WIDTH-1:0] rd_data;

   modport master (
      output sel_en, wr_rd_s, addr, wr_data,
      input  ack, rd_data
   );

   modport slave (
      input  sel_en, wr_rd_s, addr, wr_data,
      output ack, rd_data
   );
endinterface

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requesting index at or after
// the rotating pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_grant_vld
);

   int w_dist;
   int w_best;

   // Choose the requester with the smallest distance from the pointer
   always_comb begin
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      w_best      = NUM_REQ;
      w_dist      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = i - int'(i_rr_ptr);
         if (w_dist < 0) begin
            w_dist = w_dist + NUM_REQ;
         end else begin
            w_dist = w_dist;
         end
         if (i_req[i] && (w_dist < w_best)) begin
            w_best      = w_dist;
            o_grant_idx = IDX_W'(i);
            o_grant_vld = 1'b1;
         end else begin
            w_best = w_best;
         end
      end
   end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Register bus arbiter: grants one master at a time round-robin, drives a
// single bus transaction, waits for decoder ack (or times out) and returns
// a one-cycle completion with read data / error flag.
module reg_bus_arbiter
   import reg_bus_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int W_WIDTH     = REG_W_WIDTH,
   parameter int TIMEOUT_CYC = REG_TIMEOUT_CYC
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_wr_rd_s,
   input  logic [NUM_REQ*W_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*W_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         done,
   output logic [W_WIDTH-1:0]         rsp_rdata,
   output logic                       rsp_err,
   reg_bus_arbiter_if.master          bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   state_e             r_state;
   state_e             w_state_next;
   logic [IDX_W-1:0]   r_rr_ptr,    w_rr_ptr_next;
   logic [IDX_W-1:0]   r_grant,     w_grant_next;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_next;
   logic               r_sel_en,    w_sel_en_next;
   logic               r_wr_rd_s,   w_wr_rd_s_next;
   logic [W_WIDTH-1:0] r_addr,      w_addr_next;
   logic [W_WIDTH-1:0] r_wr_data,   w_wr_data_next;
   logic [NUM_REQ-1:0] r_done,      w_done_next;
   logic [W_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_next;
   logic               r_rsp_err,   w_rsp_err_next;

   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_vld;
   logic               w_pick_wr;
   logic [W_WIDTH-1:0] w_pick_addr;
   logic [W_WIDTH-1:0] w_pick_wdata;
   logic [NUM_REQ-1:0] w_grant_onehot;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req       (req),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant_idx (w_pick_idx),
      .o_grant_vld (w_pick_vld)
   );

   // Mux the picked master's command fields and decode the held grant
   always_comb begin
      w_pick_wr      = 1'b0;
      w_pick_addr    = '0;
      w_pick_wdata   = '0;
      w_grant_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_idx == IDX_W'(i)) begin
            w_pick_wr    = req_wr_rd_s[i];
            w_pick_addr  = req_addr[i*W_WIDTH +: W_WIDTH];
            w_pick_wdata = req_wdata[i*W_WIDTH +: W_WIDTH];
         end else begin
            w_pick_wr = w_pick_wr;
         end
         w_grant_onehot[i] = (r_grant == IDX_W'(i));
      end
   end

   // Next-state and next-output logic; bus command holds unless changed
   always_comb begin
      w_state_next     = r_state;
      w_rr_ptr_next    = r_rr_ptr;
      w_grant_next     = r_grant;
      w_cnt_next       = r_cnt;
      w_sel_en_next    = r_sel_en;
      w_wr_rd_s_next   = r_wr_rd_s;
      w_addr_next      = r_addr;
      w_wr_data_next   = r_wr_data;
      w_done_next      = '0;
      w_rsp_rdata_next = '0;
      w_rsp_err_next   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_grant_next   = w_pick_idx;
               w_wr_rd_s_next = w_pick_wr;
               w_addr_next    = w_pick_addr;
               w_wr_data_next = w_pick_wdata;
               w_sel_en_next  = 1'b1;
               w_cnt_next     = '0;
               w_state_next   = ACCESS;
               if (w_pick_idx == IDX_W'(NUM_REQ - 1)) begin
                  w_rr_ptr_next = '0;
               end else begin
                  w_rr_ptr_next = w_pick_idx + IDX_W'(1);
               end
            end else begin
               w_sel_en_next  = 1'b0;
               w_wr_rd_s_next = 1'b0;
               w_addr_next    = '0;
               w_wr_data_next = '0;
            end
         end

         ACCESS: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            // ack takes precedence over a simultaneous timeout
            if (bus.ack) begin
               w_done_next      = w_grant_onehot;
               w_rsp_rdata_next = (r_wr_rd_s == WR) ? '0 : bus.rd_data;
               w_rsp_err_next   = 1'b0;
               w_sel_en_next    = 1'b0;
               w_wr_rd_s_next   = 1'b0;
               w_addr_next      = '0;
               w_wr_data_next   = '0;
               w_state_next     = RESP;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               w_done_next      = w_grant_onehot;
               w_rsp_rdata_next = '0;
               w_rsp_err_next   = 1'b1;
               w_sel_en_next    = 1'b0;
               w_wr_rd_s_next   = 1'b0;
               w_addr_next      = '0;
               w_wr_data_next   = '0;
               w_state_next     = RESP;
            end else begin
               w_state_next = ACCESS;
            end
         end

         // Completion is visible this cycle; trailing decoder ack ignored
         RESP: begin
            w_sel_en_next  = 1'b0;
            w_wr_rd_s_next = 1'b0;
            w_addr_next    = '0;
            w_wr_data_next = '0;
            w_state_next   = GAP;
         end

         // Idle cycle so decoder ack / write enables can clear
         GAP: begin
            w_sel_en_next  = 1'b0;
            w_wr_rd_s_next = 1'b0;
            w_addr_next    = '0;
            w_wr_data_next = '0;
            w_state_next   = IDLE;
         end

         default: begin
            w_sel_en_next  = 1'b0;
            w_wr_rd_s_next = 1'b0;
            w_addr_next    = '0;
            w_wr_data_next = '0;
            w_state_next   = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Arbitration, counter, bus command and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_cnt       <= '0;
         r_sel_en    <= 1'b0;
         r_wr_rd_s   <= 1'b0;
         r_addr      <= '0;
         r_wr_data   <= '0;
         r_done      <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rr_ptr    <= w_rr_ptr_next;
         r_grant     <= w_grant_next;
         r_cnt       <= w_cnt_next;
         r_sel_en    <= w_sel_en_next;
         r_wr_rd_s   <= w_wr_rd_s_next;
         r_addr      <= w_addr_next;
         r_wr_data   <= w_wr_data_next;
         r_done      <= w_done_next;
         r_rsp_rdata <= w_rsp_rdata_next;
         r_rsp_err   <= w_rsp_err_next;
      end
   end

   assign bus.sel_en  = r_sel_en;
   assign bus.wr_rd_s = r_wr_rd_s;
   assign bus.addr    = r_addr;
   assign bus.wr_data = r_wr_data;
   assign done        = r_done;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the switch's single register configuration bus among NUM_REQ masters, such as the host interface and the debug port.
- Grants the bus round-robin and issues one transaction at a time (sel_en, wr_rd_s, addr, wr_data).
- Waits for the OR-ed ack from the per-register decoders, captures read data and returns a one-cycle completion to the granted master.
- Times out accesses to undecoded addresses and reports them as errors.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- W_WIDTH, 8, address/data width of the register bus.
- TIMEOUT_CYC, 16, maximum cycles sel_en is held without ack before an error completion (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-master request; held high until that master's done.
- req_wr_rd_s  in  NUM_REQ  per-master direction; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*W_WIDTH  packed per-master register address; master i at [i*W_WIDTH +: W_WIDTH].
- req_wdata  in  NUM_REQ*W_WIDTH  packed per-master write data.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted master.
- rsp_rdata  out  W_WIDTH  read data; valid while done is high, 0 otherwise.
- rsp_err  out  1  timeout flag; valid while done is high.
- sel_en  out  1  bus select to decoders.
- wr_rd_s  out  1  bus direction.
- addr  out  W_WIDTH  bus address.
- wr_data  out  W_WIDTH  bus write data.
- ack  in  1  OR of decoder acks; registered at decoders, so it rises no earlier than 1 cycle after sel_en.
- rd_data  in  W_WIDTH  OR of decoder read data; valid when ack is high.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, rr_ptr = 0, timeout counter = 0.
  - All outputs 0: done, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr, wr_data.
  - Reset during ACCESS or RESP abandons the transaction; no done is issued.
- FSM states: IDLE, ACCESS, RESP, GAP.
- IDLE:
  - If |req, select the first requesting index starting at rr_ptr, wrapping modulo NUM_REQ.
  - Register grant index, wr_rd_s, addr and wr_data from that master; set sel_en = 1; clear the counter; go to ACCESS.
  - rr_ptr = grant+1 mod NUM_REQ, updated at grant time.
  - No req: all bus outputs stay 0.
- ACCESS:
  - sel_en and the command are held stable; the counter increments each cycle.
  - ack = 1: capture rd_data into rsp_rdata for reads (0 for writes); rsp_err = 0; sel_en = 0; go to RESP.
  - ack = 0 and counter == TIMEOUT_CYC-1: rsp_rdata = 0; rsp_err = 1; sel_en = 0; go to RESP.
  - If ack arrives in the same cycle the counter reaches its limit, ack wins and rsp_err = 0.
- RESP:
  - done[grant] = 1 for exactly one cycle, with rsp_rdata and rsp_err valid.
  - ack is ignored here (decoder ack trails sel_en by one cycle).
  - Go to GAP.
- GAP:
  - done = 0, rsp_rdata = 0, rsp_err = 0, bus outputs 0.
  - One idle cycle that lets decoder ack and wr_en clear; go to IDLE.
- Latency:
  - req sampled in IDLE at edge 0; sel_en high in cycle 1; ack seen at edge 2; done in cycle 3.
  - Minimum back-to-back spacing is 5 cycles per transaction (IDLE, ACCESS x2, RESP, GAP).
  - A timed-out access takes TIMEOUT_CYC+3 cycles.
- Requester rules:
  - Command fields are sampled only at grant.
  - req dropping mid-transaction does not abort it; done is still issued.
  - A master still holding req after its done is re-arbitrated normally, behind others by round-robin.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,NUM_REQ-1.
- ack outside ACCESS never changes state or outputs.

Decomposition:
- Shared package reg_bus_pkg holds:
  - State enum: IDLE, ACCESS, RESP, GAP.
  - Default constants REG_W_WIDTH = 8 and REG_TIMEOUT_CYC = 16.
  - Direction constants WR = 1, RD = 0.
- One sub-module, rr_arbiter: combinational round-robin pick (req, rr_ptr -> grant index, grant valid), parameterised by NUM_REQ.
- FSM, counter and bus registers stay in reg_bus_arbiter.

Test Plan:
- Reset mid-access: assert rst_n low while sel_en = 1 -> all outputs 0 immediately; no done; the next req is granted master 0 first.
- Single write: master 0 writes addr = 8'h03, wdata = 8'hA5; decoder acks 1 cycle after sel_en -> sel_en high exactly 2 cycles with addr 03 and wr_data A5; done[0] pulses 1 cycle, 3 cycles after grant; rsp_err = 0.
- Single read: master 1 reads addr 8'h05; decoder returns rd_data = 8'h3C with ack -> done[1] = 1 with rsp_rdata = 3C; rsp_rdata = 0 the cycle after.
- Timeout: read addr 8'hFF, no ack -> sel_en held 16 cycles; done[0] with rsp_err = 1 and rsp_rdata = 0; next state is GAP, then IDLE.
- Contention: masters 0 and 1 request continuously with rr_ptr = 0 -> grant order 0,1,0,1; transactions never overlap; GAP cycle present between each.
- Late ack: ack arrives in the cycle the counter reaches 15 -> rsp_err = 0 and data is captured; a spurious ack pulse in IDLE -> no state or output change.
